// File: rtl/srpt_pkg.sv
// srpt_pkg: shared SRPT queue entry layout, priority codes, DMA sizing and types
//   ENTRY_*            bit ranges of the 99-bit queue entry
//   srpt_prio_e        SRPT_* priority codes carried in the entry
//   CACHE_BLOCK_SIZE   bytes moved per fetch entry
//   HOMA_PAYLOAD_SIZE  bytes of payload per Homa data packet
//   dma_tag_width()    tag width for a given number of outstanding reads
package srpt_pkg;

   localparam int ENTRY_W            = 99;
   localparam int ENTRY_PRIO_LO      = 0;
   localparam int ENTRY_PRIO_HI      = 2;
   localparam int ENTRY_GRANTED_LO   = 3;
   localparam int ENTRY_GRANTED_HI   = 22;
   localparam int ENTRY_DBUFFERED_LO = 23;
   localparam int ENTRY_DBUFFERED_HI = 42;
   localparam int ENTRY_REMAINING_LO = 43;
   localparam int ENTRY_REMAINING_HI = 62;
   localparam int ENTRY_DBUFF_ID_LO  = 63;
   localparam int ENTRY_DBUFF_ID_HI  = 71;
   localparam int ENTRY_RPC_ID_LO    = 72;
   localparam int ENTRY_RPC_ID_HI    = 87;
   localparam int ENTRY_RSVD_LO      = 88;
   localparam int ENTRY_RSVD_HI      = 98;

   localparam int CACHE_BLOCK_SIZE   = 64;
   localparam int HOMA_PAYLOAD_SIZE  = 1386;

   typedef enum logic [2:0] {
      SRPT_INVALIDATE,
      SRPT_DBUFF_UPDATE,
      SRPT_GRANT,
      SRPT_EMPTY,
      SRPT_BLOCKED,
      SRPT_ACTIVE
   } srpt_prio_e;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      ISSUE
   } issue_state_e;

   // What a completion needs to build its notification
   typedef struct packed {
      logic [15:0] rpc_id;
      logic [8:0]  dbuff_id;
      logic [19:0] offset;
      logic [6:0]  len;
   } dma_tag_entry_t;

   function automatic int dma_tag_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/srpt_tag_alloc.sv
// srpt_tag_alloc: DMA tag free bitmap with lowest-free allocation
//   ap_clk, ap_rst_n   clock, synchronous active-low reset (all tags free)
//   alloc              take alloc_tag this cycle
//   alloc_tag          lowest-numbered free tag
//   any_free           at least one tag is free
//   rel, rel_tag       release rel_tag this cycle
//   rel_used           rel_tag is currently allocated
module srpt_tag_alloc import srpt_pkg::*; #(
   parameter int N = 16
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic                         alloc,
   output logic [dma_tag_width(N)-1:0]  alloc_tag,
   output logic                         any_free,
   input  logic                         rel,
   input  logic [dma_tag_width(N)-1:0]  rel_tag,
   output logic                         rel_used
);

   localparam int TW = dma_tag_width(N);

   logic [N-1:0] used;

   // Encoder looks only at the registered bitmap, so a released tag
   // becomes allocatable one cycle later
   always_comb begin
      alloc_tag = '0;
      for (int i = N - 1; i >= 0; i--)
         if (!used[i]) alloc_tag = TW'(i);
   end

   assign any_free = ~&used;
   assign rel_used = used[rel_tag];

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) used <= '0;
      else used <= (used | (N'(alloc) << alloc_tag)) & ~(N'(rel) << rel_tag);
   end

endmodule

// File: rtl/srpt_fetch_dma_issue.sv
// srpt_fetch_dma_issue: turns SRPT fetch entries into host DMA reads and completions into dbuff updates
//   ap_clk, ap_rst_n          clock, synchronous active-low reset
//   fetch_in_*                FWFT fetch FIFO (empty, read enable, 99-bit entry)
//   addr_wr_*                 per-RPC host base address table write
//   dma_rd_req_*              read request: addr, len (1..64), tag
//   dma_rd_cpl_*              read completion by tag
//   dbuff_notif_*             rpc, dbuff slot and bytes buffered after the block
//   err_spurious_cpl_o        sticky flag for a completion on a free tag
module srpt_fetch_dma_issue import srpt_pkg::*; #(
   parameter int MAX_RPCS        = 64,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                                       ap_clk,
   input  logic                                       ap_rst_n,
   input  logic                                       fetch_in_empty_i,
   output logic                                       fetch_in_read_en_o,
   input  logic [ENTRY_W-1:0]                         fetch_in_data_i,
   input  logic                                       addr_wr_en_i,
   input  logic [15:0]                                addr_wr_rpc_i,
   input  logic [63:0]                                addr_wr_base_i,
   output logic                                       dma_rd_req_valid_o,
   input  logic                                       dma_rd_req_ready_i,
   output logic [63:0]                                dma_rd_req_addr_o,
   output logic [6:0]                                 dma_rd_req_len_o,
   output logic [dma_tag_width(MAX_OUTSTANDING)-1:0]  dma_rd_req_tag_o,
   input  logic                                       dma_rd_cpl_valid_i,
   output logic                                       dma_rd_cpl_ready_o,
   input  logic [dma_tag_width(MAX_OUTSTANDING)-1:0]  dma_rd_cpl_tag_i,
   output logic                                       dbuff_notif_valid_o,
   input  logic                                       dbuff_notif_ready_i,
   output logic [15:0]                                dbuff_notif_rpc_id_o,
   output logic [8:0]                                 dbuff_notif_dbuff_id_o,
   output logic [19:0]                                dbuff_notif_dbuffered_o,
   output logic                                       err_spurious_cpl_o
);

   localparam int TW = dma_tag_width(MAX_OUTSTANDING);
   localparam int RW = $clog2(MAX_RPCS);

   issue_state_e   state;
   logic [15:0]    in_rpc, rpc_q;
   logic [8:0]     in_dbuff, dbuff_q;
   logic [19:0]    in_rem, rem_q, in_off, off_q;
   logic [TW-1:0]  tag_q, alloc_tag;
   logic [63:0]    base_q;
   logic [6:0]     len_c;
   logic           pop, take, any_free, cpl_acc, cpl_used, unused;
   dma_tag_entry_t cpl_ent;

   logic [63:0]    addr_tab [MAX_RPCS];
   dma_tag_entry_t tag_tab  [MAX_OUTSTANDING];

   assign in_rpc   = fetch_in_data_i[ENTRY_RPC_ID_HI:ENTRY_RPC_ID_LO];
   assign in_dbuff = fetch_in_data_i[ENTRY_DBUFF_ID_HI:ENTRY_DBUFF_ID_LO];
   assign in_rem   = fetch_in_data_i[ENTRY_REMAINING_HI:ENTRY_REMAINING_LO];
   assign in_off   = fetch_in_data_i[ENTRY_DBUFFERED_HI:ENTRY_DBUFFERED_LO];
   assign unused   = ^{fetch_in_data_i[ENTRY_RSVD_HI:ENTRY_RSVD_LO],
                       fetch_in_data_i[ENTRY_GRANTED_HI:ENTRY_PRIO_LO],
                       addr_wr_rpc_i[15:RW]};

   // Entries with nothing left are popped and dropped without taking a tag
   assign pop  = ap_rst_n && state == IDLE && !fetch_in_empty_i && any_free;
   assign take = pop && in_rem != '0;
   assign fetch_in_read_en_o = pop;

   assign dma_rd_cpl_ready_o = ap_rst_n && (!dbuff_notif_valid_o || dbuff_notif_ready_i);
   assign cpl_acc = dma_rd_cpl_valid_i && dma_rd_cpl_ready_o;
   assign cpl_ent = tag_tab[dma_rd_cpl_tag_i];

   assign len_c = (rem_q > 20'(CACHE_BLOCK_SIZE)) ? 7'(CACHE_BLOCK_SIZE) : rem_q[6:0];

   srpt_tag_alloc #(.N(MAX_OUTSTANDING)) u_tags (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .alloc     (take),
      .alloc_tag (alloc_tag),
      .any_free  (any_free),
      .rel       (cpl_acc && cpl_used),
      .rel_tag   (dma_rd_cpl_tag_i),
      .rel_used  (cpl_used)
   );

   // Unreset tables; a same-cycle write and lookup of one RPC reads the old base
   always_ff @(posedge ap_clk) begin
      if (addr_wr_en_i) addr_tab[addr_wr_rpc_i[RW-1:0]] <= addr_wr_base_i;
      if (take) base_q <= addr_tab[in_rpc[RW-1:0]];
      if (state == LOOKUP) tag_tab[tag_q] <= {rpc_q, dbuff_q, off_q, len_c};
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state              <= IDLE;
         dma_rd_req_valid_o <= 1'b0;
         dma_rd_req_addr_o  <= '0;
         dma_rd_req_len_o   <= '0;
         dma_rd_req_tag_o   <= '0;
      end else begin
         unique case (state)
            IDLE: if (take) begin
               rpc_q   <= in_rpc;
               dbuff_q <= in_dbuff;
               rem_q   <= in_rem;
               off_q   <= in_off;
               tag_q   <= alloc_tag;
               state   <= LOOKUP;
            end
            LOOKUP: begin
               dma_rd_req_addr_o  <= base_q + 64'(off_q);
               dma_rd_req_len_o   <= len_c;
               dma_rd_req_tag_o   <= tag_q;
               dma_rd_req_valid_o <= 1'b1;
               state              <= ISSUE;
            end
            ISSUE: if (dma_rd_req_ready_i) begin
               dma_rd_req_valid_o <= 1'b0;
               state              <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         dbuff_notif_valid_o     <= 1'b0;
         dbuff_notif_rpc_id_o    <= '0;
         dbuff_notif_dbuff_id_o  <= '0;
         dbuff_notif_dbuffered_o <= '0;
         err_spurious_cpl_o      <= 1'b0;
      end else begin
         if (cpl_acc && cpl_used) begin
            dbuff_notif_valid_o     <= 1'b1;
            dbuff_notif_rpc_id_o    <= cpl_ent.rpc_id;
            dbuff_notif_dbuff_id_o  <= cpl_ent.dbuff_id;
            dbuff_notif_dbuffered_o <= cpl_ent.offset + 20'(cpl_ent.len);
         end else if (dbuff_notif_ready_i) begin
            dbuff_notif_valid_o <= 1'b0;
         end
         if (cpl_acc && !cpl_used) err_spurious_cpl_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_srpt_fetch_dma_issue.sv
// tb_srpt_fetch_dma_issue: directed self-checking bench for srpt_fetch_dma_issue
module tb_srpt_fetch_dma_issue;
   import srpt_pkg::*;

   logic                ap_clk, ap_rst_n;
   logic                fetch_in_empty_i, fetch_in_read_en_o;
   logic [ENTRY_W-1:0]  fetch_in_data_i;
   logic                addr_wr_en_i;
   logic [15:0]         addr_wr_rpc_i;
   logic [63:0]         addr_wr_base_i;
   logic                dma_rd_req_valid_o, dma_rd_req_ready_i;
   logic [63:0]         dma_rd_req_addr_o;
   logic [6:0]          dma_rd_req_len_o;
   logic [3:0]          dma_rd_req_tag_o;
   logic                dma_rd_cpl_valid_i, dma_rd_cpl_ready_o;
   logic [3:0]          dma_rd_cpl_tag_i;
   logic                dbuff_notif_valid_o, dbuff_notif_ready_i;
   logic [15:0]         dbuff_notif_rpc_id_o;
   logic [8:0]          dbuff_notif_dbuff_id_o;
   logic [19:0]         dbuff_notif_dbuffered_o;
   logic                err_spurious_cpl_o;

   int checks = 0;
   int errors = 0;

   logic [ENTRY_W-1:0] mem [64];
   int wr_ptr = 0;
   int rd_ptr = 0;

   srpt_fetch_dma_issue dut (
      .ap_clk                  (ap_clk),
      .ap_rst_n                (ap_rst_n),
      .fetch_in_empty_i        (fetch_in_empty_i),
      .fetch_in_read_en_o      (fetch_in_read_en_o),
      .fetch_in_data_i         (fetch_in_data_i),
      .addr_wr_en_i            (addr_wr_en_i),
      .addr_wr_rpc_i           (addr_wr_rpc_i),
      .addr_wr_base_i          (addr_wr_base_i),
      .dma_rd_req_valid_o      (dma_rd_req_valid_o),
      .dma_rd_req_ready_i      (dma_rd_req_ready_i),
      .dma_rd_req_addr_o       (dma_rd_req_addr_o),
      .dma_rd_req_len_o        (dma_rd_req_len_o),
      .dma_rd_req_tag_o        (dma_rd_req_tag_o),
      .dma_rd_cpl_valid_i      (dma_rd_cpl_valid_i),
      .dma_rd_cpl_ready_o      (dma_rd_cpl_ready_o),
      .dma_rd_cpl_tag_i        (dma_rd_cpl_tag_i),
      .dbuff_notif_valid_o     (dbuff_notif_valid_o),
      .dbuff_notif_ready_i     (dbuff_notif_ready_i),
      .dbuff_notif_rpc_id_o    (dbuff_notif_rpc_id_o),
      .dbuff_notif_dbuff_id_o  (dbuff_notif_dbuff_id_o),
      .dbuff_notif_dbuffered_o (dbuff_notif_dbuffered_o),
      .err_spurious_cpl_o      (err_spurious_cpl_o)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   // First-word-fall-through FIFO model
   assign fetch_in_empty_i = (rd_ptr == wr_ptr);
   assign fetch_in_data_i  = mem[rd_ptr % 64];
   always @(posedge ap_clk) if (fetch_in_read_en_o) rd_ptr <= rd_ptr + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   function automatic logic [ENTRY_W-1:0] mk(input int rpc, input int dbuff, input int rem, input int off);
      logic [ENTRY_W-1:0] e;
      e = '0;
      e[ENTRY_PRIO_HI:ENTRY_PRIO_LO]           = SRPT_ACTIVE;
      e[ENTRY_GRANTED_HI:ENTRY_GRANTED_LO]     = 20'habcde;
      e[ENTRY_RSVD_HI:ENTRY_RSVD_LO]           = 11'h5a5;
      e[ENTRY_RPC_ID_HI:ENTRY_RPC_ID_LO]       = 16'(rpc);
      e[ENTRY_DBUFF_ID_HI:ENTRY_DBUFF_ID_LO]   = 9'(dbuff);
      e[ENTRY_REMAINING_HI:ENTRY_REMAINING_LO] = 20'(rem);
      e[ENTRY_DBUFFERED_HI:ENTRY_DBUFFERED_LO] = 20'(off);
      return e;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge ap_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic push(input int rpc, input int dbuff, input int rem, input int off);
      mem[wr_ptr % 64] = mk(rpc, dbuff, rem, off);
      wr_ptr++;
   endtask

   task automatic wait_req(input string nm, input logic [63:0] a, input int l, input int t, input bit acc);
      int n = 0;
      while (!dma_rd_req_valid_o && n < 20) begin
         step(1);
         n++;
      end
      chk({nm, " valid"}, dma_rd_req_valid_o, 1);
      chk({nm, " addr"}, dma_rd_req_addr_o, a);
      chk({nm, " len"}, dma_rd_req_len_o, l);
      chk({nm, " tag"}, dma_rd_req_tag_o, t);
      if (acc) begin
         dma_rd_req_ready_i = 1'b1;
         step(1);
         dma_rd_req_ready_i = 1'b0;
      end
   endtask

   task automatic cpl(input int t);
      dma_rd_cpl_valid_i = 1'b1;
      dma_rd_cpl_tag_i   = 4'(t);
      step(1);
      dma_rd_cpl_valid_i = 1'b0;
   endtask

   task automatic chk_notif(input string nm, input int rpc, input int dbuff, input int dbuffered);
      chk({nm, " valid"}, dbuff_notif_valid_o, 1);
      chk({nm, " rpc"}, dbuff_notif_rpc_id_o, rpc);
      chk({nm, " dbuff"}, dbuff_notif_dbuff_id_o, dbuff);
      chk({nm, " dbuffered"}, dbuff_notif_dbuffered_o, dbuffered);
      dbuff_notif_ready_i = 1'b1;
      step(1);
      dbuff_notif_ready_i = 1'b0;
   endtask

   initial begin
      ap_rst_n            = 1'b0;
      addr_wr_en_i        = 1'b0;
      addr_wr_rpc_i       = '0;
      addr_wr_base_i      = '0;
      dma_rd_req_ready_i  = 1'b0;
      dma_rd_cpl_valid_i  = 1'b0;
      dma_rd_cpl_tag_i    = '0;
      dbuff_notif_ready_i = 1'b0;
      step(3);
      chk("rst req_valid", dma_rd_req_valid_o, 0);
      chk("rst req_addr", dma_rd_req_addr_o, 0);
      chk("rst notif_valid", dbuff_notif_valid_o, 0);
      chk("rst err", err_spurious_cpl_o, 0);
      chk("rst read_en", fetch_in_read_en_o, 0);
      chk("rst cpl_ready", dma_rd_cpl_ready_o, 0);
      ap_rst_n = 1'b1;

      addr_wr_en_i   = 1'b1;
      addr_wr_rpc_i  = 16'd7;
      addr_wr_base_i = 64'h1000_0000;
      step(1);
      addr_wr_rpc_i  = 16'd9;
      addr_wr_base_i = 64'h2000_0000;
      step(1);
      addr_wr_en_i   = 1'b0;
      chk("idle cpl_ready", dma_rd_cpl_ready_o, 1);

      // First block of a fresh message: pop, lookup, issue two cycles after pop
      push(7, 7, 512, 0);
      #1;
      chk("t1 pop", fetch_in_read_en_o, 1);
      step(1);
      chk("t1 lookup no valid", dma_rd_req_valid_o, 0);
      step(1);
      wait_req("t1", 64'h1000_0000, 64, 0, 1);
      chk("t1 req dropped", dma_rd_req_valid_o, 0);
      cpl(0);
      chk_notif("t1 notif", 7, 7, 64);

      // Short tail block at an offset
      push(7, 3, 20, 1344);
      wait_req("t2", 64'h1000_0540, 20, 0, 1);
      cpl(0);
      chk_notif("t2 notif", 7, 3, 1364);

      // Nothing remaining: popped, no request
      push(7, 4, 0, 0);
      #1;
      chk("t3 pop", fetch_in_read_en_o, 1);
      step(1);
      chk("t3 fifo drained", fetch_in_empty_i, 1);
      step(3);
      chk("t3 no req", dma_rd_req_valid_o, 0);

      // Exhaust all 16 tags, 17th waits until a tag comes back
      for (int i = 0; i < 17; i++) push(9, i, 64, i * 64);
      for (int i = 0; i < 16; i++)
         wait_req($sformatf("t4 req%0d", i), 64'h2000_0000 + 64'(i * 64), 64, i, 1);
      step(5);
      chk("t4 stall valid", dma_rd_req_valid_o, 0);
      chk("t4 stall pop", fetch_in_read_en_o, 0);
      chk("t4 entry held", fetch_in_empty_i, 0);
      cpl(5);
      chk_notif("t4 cpl5", 9, 5, 384);
      wait_req("t4 req16", 64'h2000_0400, 64, 5, 1);

      // Spurious completion on a freed tag
      cpl(3);
      chk_notif("t5 cpl3", 9, 3, 256);
      cpl(3);
      chk("t5 no notif", dbuff_notif_valid_o, 0);
      chk("t5 err", err_spurious_cpl_o, 1);
      step(3);
      chk("t5 err sticky", err_spurious_cpl_o, 1);

      // Notification backpressure
      dma_rd_cpl_valid_i = 1'b1;
      dma_rd_cpl_tag_i   = 4'd0;
      step(1);
      dma_rd_cpl_tag_i   = 4'd1;
      chk("t6 first valid", dbuff_notif_valid_o, 1);
      chk("t6 cpl blocked", dma_rd_cpl_ready_o, 0);
      step(2);
      chk("t6 held valid", dbuff_notif_valid_o, 1);
      chk("t6 held dbuff", dbuff_notif_dbuff_id_o, 0);
      chk("t6 held dbuffered", dbuff_notif_dbuffered_o, 64);
      chk("t6 still blocked", dma_rd_cpl_ready_o, 0);
      dbuff_notif_ready_i = 1'b1;
      #1;
      chk("t6 cpl released", dma_rd_cpl_ready_o, 1);
      step(1);
      dma_rd_cpl_valid_i = 1'b0;
      chk("t6 second valid", dbuff_notif_valid_o, 1);
      chk("t6 second dbuff", dbuff_notif_dbuff_id_o, 1);
      chk("t6 second dbuffered", dbuff_notif_dbuffered_o, 128);
      step(1);
      dbuff_notif_ready_i = 1'b0;
      chk("t6 drained", dbuff_notif_valid_o, 0);
      chk("t6 err kept", err_spurious_cpl_o, 1);

      // Clean reset, then reset again in the middle of an issue
      ap_rst_n = 1'b0;
      step(2);
      chk("t7 rst clears err", err_spurious_cpl_o, 0);
      ap_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) push(9, 20 + i, 128, i * 64);
      for (int i = 0; i < 3; i++)
         wait_req($sformatf("t7 req%0d", i), 64'h2000_0000 + 64'(i * 64), 64, i, 1);
      wait_req("t7 req3", 64'h2000_00c0, 64, 3, 0);
      cpl(2);
      chk("t7 notif pending", dbuff_notif_valid_o, 1);
      chk("t7 req pending", dma_rd_req_valid_o, 1);
      ap_rst_n = 1'b0;
      step(1);
      chk("t7 rst req_valid", dma_rd_req_valid_o, 0);
      chk("t7 rst req_addr", dma_rd_req_addr_o, 0);
      chk("t7 rst req_len", dma_rd_req_len_o, 0);
      chk("t7 rst req_tag", dma_rd_req_tag_o, 0);
      chk("t7 rst notif_valid", dbuff_notif_valid_o, 0);
      chk("t7 rst notif_rpc", dbuff_notif_rpc_id_o, 0);
      chk("t7 rst notif_dbuffered", dbuff_notif_dbuffered_o, 0);
      chk("t7 rst read_en", fetch_in_read_en_o, 0);
      chk("t7 rst cpl_ready", dma_rd_cpl_ready_o, 0);
      ap_rst_n = 1'b1;
      step(1);
      cpl(0);
      chk("t7 late cpl no notif", dbuff_notif_valid_o, 0);
      chk("t7 late cpl err", err_spurious_cpl_o, 1);
      push(9, 30, 10, 0);
      wait_req("t7 post rst", 64'h2000_0000, 10, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
